// File: rtl/pipe_pkg.sv
// Shared definitions for the N-channel pipeline with one arbitrated stage.
// Holds the shared-stage operation and channel-index sizing.
package pipe_pkg;

   localparam int OP_W = 64;

   // Callers truncate the result to their own width, so supported widths are 1..OP_W.
   function automatic logic [OP_W-1:0] shared_op(input logic [OP_W-1:0] d);
      return d + 1'b1;
   endfunction

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the shared stage resource.
// The pointer names the highest-priority channel and moves past each winner.
module rr_arbiter
   import pipe_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] grant
);

   localparam int CH_IDX_W = ch_idx_w(NUM_CH);

   logic [CH_IDX_W-1:0] rr_ptr;
   logic [CH_IDX_W-1:0] gnt_idx;
   logic                any_gnt;

   always_comb begin
      int j;
      j       = 0;
      grant   = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!any_gnt && req[j]) begin
            grant[j] = 1'b1;
            gnt_idx  = CH_IDX_W'(j);
            any_gnt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         rr_ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/shared_stage_pipe_n.sv
// N-channel DEPTH-stage pipeline; one stage shares an increment unit
// between channels through a round-robin arbiter.
module shared_stage_pipe_n
   import pipe_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int SHARED_STAGE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH*WIDTH-1:0] pipeline_inputs,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       flush,
   input  logic [NUM_CH-1:0]       in_stall,
   output logic [NUM_CH*WIDTH-1:0] pipeline_outputs,
   output logic [NUM_CH-1:0]       out_valid,
   output logic [NUM_CH-1:0]       out_stall
);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] stall;

   rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .grant(grant)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DEPTH-1:0] v_q;
      logic [WIDTH-1:0] d_q   [DEPTH];
      logic [WIDTH-1:0] d_nxt [DEPTH];
      logic             enter_v;

      if (SHARED_STAGE == 0) begin : g_enter_in
         assign enter_v = in_valid[c];
      end else begin : g_enter_q
         assign enter_v = v_q[SHARED_STAGE-1];
      end

      for (genvar k = 0; k < DEPTH; k++) begin : g_st
         logic [WIDTH-1:0] base;
         if (k == 0) begin : g_src_in
            assign base = pipeline_inputs[c*WIDTH +: WIDTH];
         end else begin : g_src_q
            assign base = d_q[k-1];
         end
         if (k == SHARED_STAGE) begin : g_op
            assign d_nxt[k] = WIDTH'(shared_op(OP_W'(base)));
         end else begin : g_pass
            assign d_nxt[k] = base;
         end
      end

      // A channel that loses arbitration freezes all of its stages.
      assign req[c]   = enter_v & ~in_stall[c] & ~flush[c];
      assign stall[c] = in_stall[c] | (req[c] & ~grant[c]);

      always_ff @(posedge clk) begin
         if (reset) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
         end else if (flush[c]) begin
            v_q <= '0;
         end else if (!stall[c]) begin
            v_q <= {v_q[DEPTH-2:0], in_valid[c]};
            for (int k = 0; k < DEPTH; k++) d_q[k] <= d_nxt[k];
         end
      end

      assign pipeline_outputs[c*WIDTH +: WIDTH] = d_q[DEPTH-1];
      assign out_valid[c] = v_q[DEPTH-1];
      assign out_stall[c] = stall[c];
   end

endmodule

// File: tb/tb_shared_stage_pipe_n.sv
// Directed bench for shared_stage_pipe_n with two 32-bit channels,
// four stages and the shared unit at stage 1.
module tb_shared_stage_pipe_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pipeline_inputs;
   logic [1:0]  in_valid;
   logic [1:0]  flush;
   logic [1:0]  in_stall;
   logic [63:0] pipeline_outputs;
   logic [1:0]  out_valid;
   logic [1:0]  out_stall;

   int n_tests = 0;
   int n_fail  = 0;

   shared_stage_pipe_n #(
      .NUM_CH      (2),
      .WIDTH       (32),
      .DEPTH       (4),
      .SHARED_STAGE(1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pipeline_inputs (pipeline_inputs),
      .in_valid        (in_valid),
      .flush           (flush),
      .in_stall        (in_stall),
      .pipeline_outputs(pipeline_outputs),
      .out_valid       (out_valid),
      .out_stall       (out_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid        = '0;
      flush           = '0;
      in_stall        = '0;
      pipeline_inputs = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 8; i++) tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data", pipeline_outputs, 64'h0);
      chk("rst_stall", 64'(out_stall), 64'h0);
      reset = 1'b0;

      // single item on ch0
      for (int cyc = 0; cyc <= 5; cyc++) begin
         in_valid = (cyc == 0) ? 2'b01 : 2'b00;
         pipeline_inputs[31:0] = 32'h10;
         #1;
         if (cyc == 1) chk("t1_stall", 64'(out_stall), 64'h0);
         if (cyc >= 1 && cyc <= 3) chk("t1_early", 64'(out_valid), 64'h0);
         if (cyc == 4) begin
            chk("t1_valid", 64'(out_valid), 64'h1);
            chk("t1_data", 64'(pipeline_outputs[31:0]), 64'h11);
         end
         if (cyc == 5) chk("t1_gone", 64'(out_valid), 64'h0);
         tick();
      end
      drain();

      // collision with rr_ptr=0, then ch0 alone, then collision with rr_ptr=1
      do_reset();
      for (int cyc = 0; cyc <= 5; cyc++) begin
         in_valid = (cyc == 0) ? 2'b11 : 2'b00;
         pipeline_inputs = {32'h200, 32'h100};
         #1;
         if (cyc == 1) chk("t2_lose1", 64'(out_stall), 64'h2);
         if (cyc == 2) chk("t2_grant1", 64'(out_stall), 64'h0);
         if (cyc == 4) begin
            chk("t2_v4", 64'(out_valid), 64'h1);
            chk("t2_d0", 64'(pipeline_outputs[31:0]), 64'h101);
         end
         if (cyc == 5) begin
            chk("t2_v5", 64'(out_valid), 64'h2);
            chk("t2_d1", 64'(pipeline_outputs[63:32]), 64'h201);
         end
         tick();
      end
      drain();
      in_valid = 2'b01;
      pipeline_inputs = {32'h0, 32'h300};
      tick();
      drain();
      for (int cyc = 0; cyc <= 5; cyc++) begin
         in_valid = (cyc == 0) ? 2'b11 : 2'b00;
         pipeline_inputs = {32'h500, 32'h400};
         #1;
         if (cyc == 1) chk("t2b_lose0", 64'(out_stall), 64'h1);
         if (cyc == 4) begin
            chk("t2b_v4", 64'(out_valid), 64'h2);
            chk("t2b_d1", 64'(pipeline_outputs[63:32]), 64'h501);
         end
         if (cyc == 5) begin
            chk("t2b_v5", 64'(out_valid), 64'h1);
            chk("t2b_d0", 64'(pipeline_outputs[31:0]), 64'h401);
         end
         tick();
      end
      drain();

      // consumer back-pressure on ch1 while ch0 streams
      for (int cyc = 0; cyc <= 10; cyc++) begin
         in_valid[1] = (cyc == 0);
         in_valid[0] = (cyc >= 1 && cyc <= 6);
         pipeline_inputs = {32'hABB, 32'(cyc)};
         in_stall = (cyc >= 4 && cyc <= 6) ? 2'b10 : 2'b00;
         #1;
         chk("t3_s0", 64'(out_stall[0]), 64'h0);
         if (cyc >= 4 && cyc <= 6) begin
            chk("t3_hold_s", 64'(out_stall[1]), 64'h1);
            chk("t3_hold_v", 64'(out_valid[1]), 64'h1);
            chk("t3_hold_d", 64'(pipeline_outputs[63:32]), 64'hABC);
         end
         if (cyc == 7) begin
            chk("t3_rel_s", 64'(out_stall[1]), 64'h0);
            chk("t3_rel_v", 64'(out_valid[1]), 64'h1);
         end
         if (cyc == 8) chk("t3_nodup", 64'(out_valid[1]), 64'h0);
         if (cyc >= 5) begin
            chk("t3_c0_v", 64'(out_valid[0]), 64'h1);
            chk("t3_c0_d", 64'(pipeline_outputs[31:0]), 64'(cyc - 3));
         end
         tick();
      end
      drain();

      // flush of three ch0 items, plain and with in_stall
      for (int ws = 0; ws < 2; ws++) begin
         for (int cyc = 0; cyc <= 9; cyc++) begin
            in_valid[0] = (cyc <= 3);
            in_valid[1] = (cyc == 3);
            pipeline_inputs = {32'h600, 32'(32'h20 + cyc)};
            flush = (cyc == 3) ? 2'b01 : 2'b00;
            in_stall = (cyc == 3 && ws == 1) ? 2'b01 : 2'b00;
            #1;
            if (cyc == 3) chk("t4_s3", 64'(out_stall[0]), 64'(ws));
            if (cyc == 4) chk("t4_s4", 64'(out_stall[0]), 64'h0);
            if (cyc >= 4) chk("t4_gone", 64'(out_valid[0]), 64'h0);
            if (cyc == 7) begin
               chk("t4_c1_v", 64'(out_valid[1]), 64'h1);
               chk("t4_c1_d", 64'(pipeline_outputs[63:32]), 64'h601);
            end
            tick();
         end
         drain();
      end

      // wraparound of the increment
      for (int cyc = 0; cyc <= 4; cyc++) begin
         in_valid = (cyc == 0) ? 2'b10 : 2'b00;
         pipeline_inputs = {32'hFFFF_FFFF, 32'h0};
         #1;
         if (cyc == 4) begin
            chk("t5_v", 64'(out_valid[1]), 64'h1);
            chk("t5_d", 64'(pipeline_outputs[63:32]), 64'h0);
         end
         tick();
      end
      drain();

      // reset mid-operation with rr_ptr=1
      for (int cyc = 0; cyc <= 8; cyc++) begin
         in_valid = (cyc == 0 || cyc == 3) ? 2'b11 : (cyc == 1) ? 2'b01 : 2'b00;
         pipeline_inputs = (cyc == 3) ? {32'h70, 32'h60} : {32'h50, 32'h40};
         reset = (cyc == 2);
         #1;
         if (cyc == 2) chk("t6_ptr1", 64'(out_stall), 64'h1);
         if (cyc == 3) begin
            chk("t6_rv", 64'(out_valid), 64'h0);
            chk("t6_rd", pipeline_outputs, 64'h0);
         end
         if (cyc == 4) chk("t6_ptr0", 64'(out_stall), 64'h2);
         if (cyc >= 3 && cyc <= 6) chk("t6_empty", 64'(out_valid), 64'h0);
         if (cyc == 7) begin
            chk("t6_v7", 64'(out_valid), 64'h1);
            chk("t6_d0", 64'(pipeline_outputs[31:0]), 64'h61);
         end
         if (cyc == 8) begin
            chk("t6_v8", 64'(out_valid), 64'h2);
            chk("t6_d1", 64'(pipeline_outputs[63:32]), 64'h71);
         end
         tick();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
